// File: rtl/mux_scan_serializer_if.sv
// mux_scan_serializer_if
//   Byte-in / bit-out handshake bundle for mux_scan_serializer.
//   in_valid  : upstream byte valid
//   in_ready  : serializer can accept a byte
//   in_data   : byte to serialize
//   ser_data  : serial bit (holds between strobes)
//   ser_valid : one-cycle strobe, ser_data valid this cycle
//   ser_last  : marks the final strobe of a frame
//   modport master : byte producer / bit consumer side
//   modport slave  : serializer side
interface mux_scan_serializer_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       ser_data;
   logic       ser_valid;
   logic       ser_last;

   modport master (
      output in_valid, in_data,
      input  in_ready, ser_data, ser_valid, ser_last
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, ser_data, ser_valid, ser_last
   );
endinterface

// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer
//   Parallel-to-serial front end for an external 8:1 bit-select mux. A byte
//   accepted on the handshake is registered onto mux_in; the select is then
//   stepped through all eight positions, one bit period (BIT_CYCLES clocks)
//   each, and mux_out is sampled at the end of every period into a framed
//   serial stream.
//   Parameters : BIT_CYCLES (1..256) clocks per bit, MSB_FIRST scan 7->0.
//   Ports      : clk, rst (sync, active-high), bus (slave modport:
//                in_valid/in_ready/in_data, ser_data/ser_valid/ser_last),
//                mux_in, mux_sel to the mux, mux_out from the mux, busy.
//   Macro      : MUX_SCAN_PARITY_EN appends an even-parity bit period.
module mux_scan_serializer #(
   parameter int BIT_CYCLES = 1,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   mux_scan_serializer_if.slave  bus,
   output logic [7:0]            mux_in,
   output logic [2:0]            mux_sel,
   input  logic                  mux_out,
   output logic                  busy
);

   localparam int             CW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [2:0]     SEL_FIRST = MSB_FIRST ? 3'd7 : 3'd0;

`ifdef MUX_SCAN_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [2:0]     bit_cnt;
   logic           period_end;

   assign period_end   = (cnt == CNT_LAST);
   assign bus.in_ready = (state == IDLE);
   assign busy         = (state != IDLE);

   // mux_sel doubles as the bit index; the exit test uses bit_cnt so the
   // index is never stepped past the eighth position.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         mux_in        <= '0;
         mux_sel       <= '0;
         bus.ser_data  <= 1'b0;
         bus.ser_valid <= 1'b0;
         bus.ser_last  <= 1'b0;
      end else begin
         bus.ser_valid <= 1'b0;
         bus.ser_last  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mux_in  <= bus.in_data;
                  mux_sel <= SEL_FIRST;
                  cnt     <= '0;
                  bit_cnt <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (period_end) begin
                  cnt           <= '0;
                  bus.ser_data  <= mux_out;
                  bus.ser_valid <= 1'b1;
                  if (bit_cnt == 3'd7) begin
`ifdef MUX_SCAN_PARITY_EN
                     state        <= PARITY;
`else
                     state        <= IDLE;
                     mux_sel      <= '0;
                     bus.ser_last <= 1'b1;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     mux_sel <= MSB_FIRST ? (mux_sel - 3'd1) : (mux_sel + 3'd1);
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef MUX_SCAN_PARITY_EN
            PARITY: begin
               if (period_end) begin
                  cnt           <= '0;
                  bus.ser_data  <= ^mux_in;
                  bus.ser_valid <= 1'b1;
                  bus.ser_last  <= 1'b1;
                  mux_sel       <= '0;
                  state         <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb_mux_scan_serializer
//   Three serializer instances (BIT_CYCLES/MSB_FIRST = 1/0, 1/1, 3/0), each
//   wired to a behavioural 8:1 mux. A frame-position reference model predicts
//   every output in every cycle from the accept cycle of the current frame.
//   Honours MUX_SCAN_PARITY_EN (9-bit frames when defined).
module tb_mux_scan_serializer;

`ifdef MUX_SCAN_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mux_scan_serializer_if if0 ();
   mux_scan_serializer_if if1 ();
   mux_scan_serializer_if if2 ();

   logic [7:0] mux_in0, mux_in1, mux_in2;
   logic [2:0] mux_sel0, mux_sel1, mux_sel2;
   logic       mux_out0, mux_out1, mux_out2;
   logic       busy0, busy1, busy2;

   // External 8:1 bit-select muxes
   assign mux_out0 = mux_in0[mux_sel0];
   assign mux_out1 = mux_in1[mux_sel1];
   assign mux_out2 = mux_in2[mux_sel2];

   mux_scan_serializer #(.BIT_CYCLES(1), .MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .bus(if0), .mux_in(mux_in0), .mux_sel(mux_sel0),
      .mux_out(mux_out0), .busy(busy0));
   mux_scan_serializer #(.BIT_CYCLES(1), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .bus(if1), .mux_in(mux_in1), .mux_sel(mux_sel1),
      .mux_out(mux_out1), .busy(busy1));
   mux_scan_serializer #(.BIT_CYCLES(3), .MSB_FIRST(1'b0)) dut2 (
      .clk(clk), .rst(rst), .bus(if2), .mux_in(mux_in2), .mux_sel(mux_sel2),
      .mux_out(mux_out2), .busy(busy2));

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model state per instance
   int         bc  [3] = '{1, 1, 3};
   bit         msb [3] = '{1'b0, 1'b1, 1'b0};
   logic       act [3];
   int         s   [3];
   logic [7:0] mb  [3];
   logic       ld  [3];
   logic [7:0] pq  [3][$];

   function automatic logic m_ready(input int i, input int c);
      int n;
      n = c - s[i];
      return !(act[i] && n >= 1 && n <= NB * bc[i]);
   endfunction

   task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s inst=%0d cycle=%0d observed=%h expected=%h", tag, i, cyc, obs, exp);
      end
   endtask

   task automatic check_inst(input int i, input logic rdy, input logic bsy, input logic sv,
                             input logic sl, input logic sd, input logic [7:0] mi,
                             input logic [2:0] ms);
      int n, j, k, b;
      logic [2:0] es;
      logic ev, el, er;
      n  = cyc - s[i];
      es = 3'd0;
      ev = 1'b0;
      el = 1'b0;
      er = m_ready(i, cyc);
      if (act[i] && n >= 1 && n <= 8 * bc[i]) begin
         k  = (n - 1) / bc[i];
         es = msb[i] ? 3'(7 - k) : 3'(k);
      end else if (NB == 9 && act[i] && n > 8 * bc[i] && n <= 9 * bc[i]) begin
         es = msb[i] ? 3'd0 : 3'd7;
      end
      if (act[i] && n >= 2 && ((n - 1) % bc[i]) == 0) begin
         j = (n - 1) / bc[i];
         if (j >= 1 && j <= NB) begin
            ev = 1'b1;
            el = (j == NB);
            if (j <= 8) begin
               b     = msb[i] ? (8 - j) : (j - 1);
               ld[i] = mb[i][b];
            end else begin
               ld[i] = ^mb[i];
            end
         end
      end
      chk("in_ready",  i, {7'd0, rdy}, {7'd0, er});
      chk("busy",      i, {7'd0, bsy}, {7'd0, !er});
      chk("mux_in",    i, mi, mb[i]);
      chk("mux_sel",   i, {5'd0, ms}, {5'd0, es});
      chk("ser_valid", i, {7'd0, sv}, {7'd0, ev});
      chk("ser_last",  i, {7'd0, sl}, {7'd0, el});
      chk("ser_data",  i, {7'd0, sd}, {7'd0, ld[i]});
   endtask

   task automatic step(input logic r);
      logic acc [3];
      rst          = r;
      if0.in_valid = (pq[0].size() != 0);
      if0.in_data  = (pq[0].size() != 0) ? pq[0][0] : 8'h00;
      if1.in_valid = (pq[1].size() != 0);
      if1.in_data  = (pq[1].size() != 0) ? pq[1][0] : 8'h00;
      if2.in_valid = (pq[2].size() != 0);
      if2.in_data  = (pq[2].size() != 0) ? pq[2][0] : 8'h00;
      for (int i = 0; i < 3; i++)
         acc[i] = !r && (pq[i].size() != 0) && m_ready(i, cyc);
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (r) begin
            act[i] = 1'b0;
            mb[i]  = 8'h00;
            ld[i]  = 1'b0;
         end else if (acc[i]) begin
            act[i] = 1'b1;
            s[i]   = cyc;
            mb[i]  = pq[i].pop_front();
         end
      end
      cyc++;
      #1;
      check_inst(0, if0.in_ready, busy0, if0.ser_valid, if0.ser_last, if0.ser_data, mux_in0, mux_sel0);
      check_inst(1, if1.in_ready, busy1, if1.ser_valid, if1.ser_last, if1.ser_data, mux_in1, mux_sel1);
      check_inst(2, if2.in_ready, busy2, if2.ser_valid, if2.ser_last, if2.ser_data, mux_in2, mux_sel2);
   endtask

   task automatic push_all(input logic [7:0] d);
      for (int i = 0; i < 3; i++) pq[i].push_back(d);
   endtask

   task automatic run(input int n);
      for (int t = 0; t < n; t++) step(1'b0);
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 3; i++) begin
         act[i] = 1'b0;
         s[i]   = 0;
         mb[i]  = 8'h00;
         ld[i]  = 1'b0;
      end
      if0.in_valid = 1'b0; if0.in_data = 8'h00;
      if1.in_valid = 1'b0; if1.in_data = 8'h00;
      if2.in_valid = 1'b0; if2.in_data = 8'h00;

      step(1'b1);
      step(1'b1);
      run(2);

      push_all(8'hA5); run(30);
      push_all(8'h01); run(30);
      push_all(8'h0F); push_all(8'hF0); run(60);
      push_all(8'h81); run(30);

      // abort a frame of 8'hFF with rst sampled at edge 4 of the frame
      push_all(8'hFF);
      step(1'b0);
      run(3);
      step(1'b1);
      run(30);
      push_all(8'h3C); run(30);
      push_all(8'h07); run(40);

      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < 3; i++)
            if (pq[i].size() == 0 && $urandom_range(0, 3) == 0)
               pq[i].push_back(8'($urandom));
         step($urandom_range(0, 79) == 0);
      end

      guard = 0;
      while ((pq[0].size() + pq[1].size() + pq[2].size() != 0 ||
              !m_ready(0, cyc) || !m_ready(1, cyc) || !m_ready(2, cyc)) && guard < 500) begin
         step(1'b0);
         guard++;
      end
      run(3);
      checks++;
      assert (guard < 500) else begin
         failures++;
         $error("FAIL drain_timeout observed=%0d expected<500", guard);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
